// File: rtl/csr_excp_unit_pkg.sv
// csr_excp_unit_pkg
//   Shared CSR index constants, field layouts and exception codes for the
//   exception/interrupt/timer CSR block.
package csr_excp_unit_pkg;

  localparam logic [13:0] CSR_CRMD      = 14'h000;
  localparam logic [13:0] CSR_PRMD      = 14'h001;
  localparam logic [13:0] CSR_ECFG      = 14'h004;
  localparam logic [13:0] CSR_ESTAT     = 14'h005;
  localparam logic [13:0] CSR_ERA       = 14'h006;
  localparam logic [13:0] CSR_BADV      = 14'h007;
  localparam logic [13:0] CSR_EENTRY    = 14'h00C;
  localparam logic [13:0] CSR_SAVE0     = 14'h030;
  localparam logic [13:0] CSR_SAVE1     = 14'h031;
  localparam logic [13:0] CSR_SAVE2     = 14'h032;
  localparam logic [13:0] CSR_SAVE3     = 14'h033;
  localparam logic [13:0] CSR_TID       = 14'h040;
  localparam logic [13:0] CSR_TCFG      = 14'h041;
  localparam logic [13:0] CSR_TVAL      = 14'h042;
  localparam logic [13:0] CSR_TICLR     = 14'h044;
  localparam logic [13:0] CSR_LLBCTL    = 14'h060;
  localparam logic [13:0] CSR_TLBRENTRY = 14'h088;

  localparam logic [5:0]  ECODE_TLBR    = 6'h3F;

  // ECFG.LIE bit 10 does not exist
  localparam logic [12:0] ECFG_LIE_MASK = 13'h1BFF;

  localparam int LLBCTL_WCLLB = 1;
  localparam int LLBCTL_KLO   = 2;
  localparam int IS_TIMER     = 11;

  typedef struct packed {
    logic       pg;
    logic       da;
    logic       ie;
    logic [1:0] plv;
  } crmd_t;

  typedef struct packed {
    logic       pie;
    logic [1:0] pplv;
  } prmd_t;

endpackage

// File: rtl/csr_excp_unit_if.sv
// csr_excp_unit_if
//   Writeback/redirect bundle between the pipeline and the CSR block.
//   master: pipeline side (drives commit events, CSR write, CSR read index)
//   slave : CSR block (returns read data, redirect targets, int/plv/llbit)
interface csr_excp_unit_if;
  logic        excp_flush;
  logic        ertn_flush;
  logic [31:0] csr_era;
  logic [5:0]  csr_ecode;
  logic [8:0]  csr_esubcode;
  logic        va_error;
  logic [31:0] bad_va;
  logic        excp_tlbrefill;
  logic        csr_wr_en;
  logic [13:0] wr_csr_addr;
  logic [31:0] wr_csr_data;
  logic        ws_llbit_set;
  logic        ws_llbit;
  logic [13:0] rd_csr_addr;
  logic [31:0] rd_csr_data;
  logic [31:0] excp_entry;
  logic [31:0] ertn_pc;
  logic        has_int;
  logic [1:0]  plv;
  logic        llbit;

  modport master (
    output excp_flush, ertn_flush, csr_era, csr_ecode, csr_esubcode,
           va_error, bad_va, excp_tlbrefill, csr_wr_en, wr_csr_addr,
           wr_csr_data, ws_llbit_set, ws_llbit, rd_csr_addr,
    input  rd_csr_data, excp_entry, ertn_pc, has_int, plv, llbit
  );

  modport slave (
    input  excp_flush, ertn_flush, csr_era, csr_ecode, csr_esubcode,
           va_error, bad_va, excp_tlbrefill, csr_wr_en, wr_csr_addr,
           wr_csr_data, ws_llbit_set, ws_llbit, rd_csr_addr,
    output rd_csr_data, excp_entry, ertn_pc, has_int, plv, llbit
  );
endinterface

// File: rtl/csr_excp_unit_timer.sv
// csr_excp_unit_timer
//   TCFG register and TVAL down-counter. fire pulses for one cycle on the
//   edge where TVAL steps from 1 to 0.
//   clk, reset      : clock, async active-low reset
//   tcfg_we         : TCFG write strobe (already qualified by priority)
//   tcfg_wdata      : TCFG write data
//   tcfg_rd/tval_rd : read-back values
//   fire            : timer terminal count
module csr_excp_unit_timer #(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_wdata,
  output logic [31:0] tcfg_rd,
  output logic [31:0] tval_rd,
  output logic        fire
);

  logic               en;
  logic               periodic;
  logic [TIMER_W-3:0] init_val;
  logic [TIMER_W-1:0] tval;
  logic [TIMER_W-1:0] reload_val;

  assign reload_val = {init_val, 2'b00};
  // A TCFG write reloads the counter, so it also suppresses the terminal count.
  assign fire       = ~tcfg_we & en & (tval == TIMER_W'(1));
  assign tcfg_rd    = 32'({init_val, periodic, en});
  assign tval_rd    = 32'(tval);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      init_val <= '0;
      tval     <= '0;
    end else if (tcfg_we) begin
      en       <= tcfg_wdata[0];
      periodic <= tcfg_wdata[1];
      init_val <= tcfg_wdata[TIMER_W-1:2];
      tval     <= {tcfg_wdata[TIMER_W-1:2], 2'b00};
    end else if (en) begin
      if (tval != '0)
        tval <= tval - TIMER_W'(1);
      else if (periodic)
        tval <= reload_val;
    end
  end

endmodule

// File: rtl/csr_excp_unit.sv
// csr_excp_unit
//   Owns the exception, interrupt, timer and llbit CSRs. Applies writeback
//   commit events (exception > ertn > CSR write), provides redirect targets,
//   the pending-interrupt flag and a combinational CSR read port.
//   clk, reset  : clock, async active-low reset
//   bus         : writeback/redirect bundle (slave side)
//   hw_int_in   : external interrupt lines, sampled into ESTAT.IS[9:2]
//   ipi_int_in  : inter-processor interrupt, sampled into ESTAT.IS[12]
module csr_excp_unit
  import csr_excp_unit_pkg::*;
#(
  parameter int          TIMER_W = 32,
  parameter logic [31:0] TID_RST = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  csr_excp_unit_if.slave  bus,
  input  logic [7:0]      hw_int_in,
  input  logic            ipi_int_in
);

  crmd_t       crmd;
  prmd_t       prmd;
  logic [12:0] ecfg_lie;
  logic [12:0] estat_is;
  logic [5:0]  estat_ecode;
  logic [8:0]  estat_esub;
  logic [31:0] era;
  logic [31:0] badv;
  logic [25:0] eentry;
  logic [25:0] tlbrentry;
  logic [31:0] save_r [4];
  logic [31:0] tid;
  logic        rollb;
  logic        klo;

  logic        ertn_only;
  logic        wr_ok;
  logic [13:0] wr_addr;
  logic [31:0] wr_data;
  logic        timer_fire;
  logic [31:0] tcfg_rd;
  logic [31:0] tval_rd;

  assign ertn_only = bus.ertn_flush & ~bus.excp_flush;
  assign wr_ok     = bus.csr_wr_en & ~bus.excp_flush & ~bus.ertn_flush;
  assign wr_addr   = bus.wr_csr_addr;
  assign wr_data   = bus.wr_csr_data;

  csr_excp_unit_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .tcfg_we   (wr_ok && wr_addr == CSR_TCFG),
    .tcfg_wdata(wr_data),
    .tcfg_rd   (tcfg_rd),
    .tval_rd   (tval_rd),
    .fire      (timer_fire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crmd        <= '{pg: 1'b0, da: 1'b1, ie: 1'b0, plv: 2'd0};
      prmd        <= '0;
      ecfg_lie    <= '0;
      estat_is    <= '0;
      estat_ecode <= '0;
      estat_esub  <= '0;
      era         <= '0;
      badv        <= '0;
      eentry      <= '0;
      tlbrentry   <= '0;
      for (int i = 0; i < 4; i++) save_r[i] <= '0;
      tid         <= TID_RST;
      rollb       <= 1'b0;
      klo         <= 1'b0;
    end else begin
      estat_is[9:2] <= hw_int_in;
      estat_is[12]  <= ipi_int_in;
      // A timer fire coinciding with a TICLR clear leaves the interrupt set.
      if (timer_fire)
        estat_is[IS_TIMER] <= 1'b1;
      else if (wr_ok && wr_addr == CSR_TICLR && wr_data[0])
        estat_is[IS_TIMER] <= 1'b0;

      if (bus.excp_flush) begin
        prmd.pplv   <= crmd.plv;
        prmd.pie    <= crmd.ie;
        crmd.plv    <= 2'd0;
        crmd.ie     <= 1'b0;
        if (bus.excp_tlbrefill) begin
          crmd.da <= 1'b1;
          crmd.pg <= 1'b0;
        end
        estat_ecode <= bus.csr_ecode;
        estat_esub  <= bus.csr_esubcode;
        era         <= bus.csr_era;
        if (bus.va_error) badv <= bus.bad_va;
      end else if (bus.ertn_flush) begin
        crmd.plv <= prmd.pplv;
        crmd.ie  <= prmd.pie;
        if (estat_ecode == ECODE_TLBR) begin
          crmd.da <= 1'b0;
          crmd.pg <= 1'b1;
        end
      end else if (bus.csr_wr_en) begin
        case (wr_addr)
          CSR_CRMD:      crmd          <= wr_data[4:0];
          CSR_PRMD:      prmd          <= wr_data[2:0];
          CSR_ECFG:      ecfg_lie      <= wr_data[12:0] & ECFG_LIE_MASK;
          CSR_ESTAT:     estat_is[1:0] <= wr_data[1:0];
          CSR_ERA:       era           <= wr_data;
          CSR_BADV:      badv          <= wr_data;
          CSR_EENTRY:    eentry        <= wr_data[31:6];
          CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                         save_r[wr_addr[1:0]] <= wr_data;
          CSR_TID:       tid           <= wr_data;
          CSR_TLBRENTRY: tlbrentry     <= wr_data[31:6];
          default: ;
        endcase
      end

      // An ertn clear outranks an ll/sc set landing in the same cycle.
      if (ertn_only && !klo)
        rollb <= 1'b0;
      else if (bus.ws_llbit_set)
        rollb <= bus.ws_llbit;
      else if (wr_ok && wr_addr == CSR_LLBCTL && wr_data[LLBCTL_WCLLB])
        rollb <= 1'b0;

      if (ertn_only)
        klo <= 1'b0;
      else if (wr_ok && wr_addr == CSR_LLBCTL)
        klo <= wr_data[LLBCTL_KLO];
    end
  end

  always_comb begin
    bus.rd_csr_data = '0;
    case (bus.rd_csr_addr)
      CSR_CRMD:      bus.rd_csr_data = {27'b0, crmd};
      CSR_PRMD:      bus.rd_csr_data = {29'b0, prmd};
      CSR_ECFG:      bus.rd_csr_data = {19'b0, ecfg_lie};
      CSR_ESTAT:     bus.rd_csr_data = {1'b0, estat_esub, estat_ecode, 3'b0, estat_is};
      CSR_ERA:       bus.rd_csr_data = era;
      CSR_BADV:      bus.rd_csr_data = badv;
      CSR_EENTRY:    bus.rd_csr_data = {eentry, 6'b0};
      CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                     bus.rd_csr_data = save_r[bus.rd_csr_addr[1:0]];
      CSR_TID:       bus.rd_csr_data = tid;
      CSR_TCFG:      bus.rd_csr_data = tcfg_rd;
      CSR_TVAL:      bus.rd_csr_data = tval_rd;
      CSR_LLBCTL:    bus.rd_csr_data = {29'b0, klo, 1'b0, rollb};
      CSR_TLBRENTRY: bus.rd_csr_data = {tlbrentry, 6'b0};
      default:       bus.rd_csr_data = '0;
    endcase
  end

  assign bus.excp_entry = bus.excp_tlbrefill ? {tlbrentry, 6'b0} : {eentry, 6'b0};
  assign bus.ertn_pc    = era;
  assign bus.has_int    = crmd.ie & |(estat_is & ecfg_lie);
  assign bus.plv        = crmd.plv;
  assign bus.llbit      = rollb;

endmodule

// File: tb/tb_csr_excp_unit.sv
// tb_csr_excp_unit
//   Directed bench: a write/read-back vector table for the CSR map, then
//   hand-written sequences for exceptions, ertn, interrupts, timer, llbit,
//   event priority and async reset.
module tb_csr_excp_unit;
  import csr_excp_unit_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] hw_int_in;
  logic       ipi_int_in;
  int         cyc;
  int         n_pass;
  int         n_total;

  csr_excp_unit_if bus ();

  csr_excp_unit #(.TIMER_W(32), .TID_RST(32'h0)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .hw_int_in (hw_int_in),
    .ipi_int_in(ipi_int_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_rd(input string name, input logic [13:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus.rd_csr_addr = a;
    #1;
    d = bus.rd_csr_data;
    check(name, d, exp);
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] d);
    bus.rd_csr_addr = a;
    #1;
    d = bus.rd_csr_data;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    bus.csr_wr_en   = 1'b1;
    bus.wr_csr_addr = a;
    bus.wr_csr_data = d;
    tick();
    bus.csr_wr_en   = 1'b0;
  endtask

  task automatic excp(input logic [5:0] ec, input logic [31:0] pc, input logic tlbr,
                      input logic vae, input logic [31:0] va);
    bus.excp_flush     = 1'b1;
    bus.csr_ecode      = ec;
    bus.csr_esubcode   = 9'h0;
    bus.csr_era        = pc;
    bus.excp_tlbrefill = tlbr;
    bus.va_error       = vae;
    bus.bad_va         = va;
    tick();
    bus.excp_flush     = 1'b0;
    bus.excp_tlbrefill = 1'b0;
    bus.va_error       = 1'b0;
  endtask

  task automatic ertn();
    bus.ertn_flush = 1'b1;
    tick();
    bus.ertn_flush = 1'b0;
  endtask

  // Ticks until ESTAT.IS[11] reads set, at most 100 cycles; returns the cycle.
  task automatic wait_timer(output int at);
    logic [31:0] d;
    at = -1;
    for (int k = 0; k < 100; k++) begin
      tick();
      rd(CSR_ESTAT, d);
      if (d[11]) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    int t0, t1, t2;
    n_pass = 0;
    n_total = 0;

    tbl[0]  = '{CSR_PRMD,      32'hffffffff, 32'h00000007};
    tbl[1]  = '{CSR_ECFG,      32'hffffffff, 32'h00001bff};
    tbl[2]  = '{CSR_ESTAT,     32'hffffffff, 32'h00000003};
    tbl[3]  = '{CSR_ERA,       32'h12345678, 32'h12345678};
    tbl[4]  = '{CSR_BADV,      32'hdeadbeef, 32'hdeadbeef};
    tbl[5]  = '{CSR_EENTRY,    32'hffffffff, 32'hffffffc0};
    tbl[6]  = '{CSR_SAVE0,     32'h11111111, 32'h11111111};
    tbl[7]  = '{CSR_SAVE3,     32'h33333333, 32'h33333333};
    tbl[8]  = '{CSR_TID,       32'h0000a5a5, 32'h0000a5a5};
    tbl[9]  = '{CSR_TLBRENTRY, 32'h1234567f, 32'h12345640};
    tbl[10] = '{CSR_TICLR,     32'hffffffff, 32'h00000000};
    tbl[11] = '{CSR_TVAL,      32'h000000ff, 32'h00000000};
    tbl[12] = '{14'h002,       32'hffffffff, 32'h00000000};
    tbl[13] = '{CSR_CRMD,      32'h0000001f, 32'h0000001f};
    tbl[14] = '{CSR_CRMD,      32'h00000008, 32'h00000008};
    tbl[15] = '{CSR_ECFG,      32'h00000000, 32'h00000000};
    tbl[16] = '{CSR_ESTAT,     32'h00000000, 32'h00000000};
    tbl[17] = '{CSR_PRMD,      32'h00000000, 32'h00000000};
    tbl[18] = '{CSR_LLBCTL,    32'h00000002, 32'h00000000};

    reset = 1'b0;
    hw_int_in = 8'h0;
    ipi_int_in = 1'b0;
    bus.excp_flush = 1'b0;
    bus.ertn_flush = 1'b0;
    bus.csr_era = '0;
    bus.csr_ecode = '0;
    bus.csr_esubcode = '0;
    bus.va_error = 1'b0;
    bus.bad_va = '0;
    bus.excp_tlbrefill = 1'b0;
    bus.csr_wr_en = 1'b0;
    bus.wr_csr_addr = '0;
    bus.wr_csr_data = '0;
    bus.ws_llbit_set = 1'b0;
    bus.ws_llbit = 1'b0;
    bus.rd_csr_addr = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // reset state
    chk_rd("rst_crmd", CSR_CRMD, 32'h8);
    chk_rd("rst_tid", CSR_TID, 32'h0);
    check("rst_has_int", 32'(bus.has_int), 32'h0);
    check("rst_plv", 32'(bus.plv), 32'h0);
    check("rst_llbit", 32'(bus.llbit), 32'h0);
    check("rst_ertn_pc", bus.ertn_pc, 32'h0);
    check("rst_excp_entry", bus.excp_entry, 32'h0);

    // CSR map write masks and read-back
    for (int i = 0; i < 19; i++) begin
      wr(tbl[i].addr, tbl[i].wdata);
      chk_rd($sformatf("tbl_%0d", i), tbl[i].addr, tbl[i].exp);
    end

    // exception then ertn
    wr(CSR_CRMD, 32'h7);
    excp(6'hB, 32'h1c000100, 1'b0, 1'b0, 32'h00005555);
    chk_rd("excp_crmd", CSR_CRMD, 32'h0);
    check("excp_plv", 32'(bus.plv), 32'h0);
    chk_rd("excp_prmd", CSR_PRMD, 32'h7);
    chk_rd("excp_era", CSR_ERA, 32'h1c000100);
    chk_rd("excp_badv_kept", CSR_BADV, 32'hdeadbeef);
    chk_rd("excp_estat", CSR_ESTAT, 32'h000b0000);
    ertn();
    check("ertn_plv", 32'(bus.plv), 32'h3);
    chk_rd("ertn_crmd", CSR_CRMD, 32'h7);
    check("ertn_pc", bus.ertn_pc, 32'h1c000100);

    // TLB refill exception
    wr(CSR_EENTRY, 32'h1c008000);
    wr(CSR_TLBRENTRY, 32'h0000f000);
    #1;
    check("entry_normal", bus.excp_entry, 32'h1c008000);
    bus.excp_tlbrefill = 1'b1;
    #1;
    check("entry_tlbr", bus.excp_entry, 32'h0000f000);
    excp(ECODE_TLBR, 32'h1c000200, 1'b1, 1'b1, 32'h80001234);
    chk_rd("tlbr_badv", CSR_BADV, 32'h80001234);
    chk_rd("tlbr_crmd", CSR_CRMD, 32'h8);
    chk_rd("tlbr_estat", CSR_ESTAT, 32'h003f0000);
    ertn();
    chk_rd("tlbr_ertn_crmd", CSR_CRMD, 32'h17);
    wr(CSR_CRMD, 32'h8);

    // interrupt line sampling
    hw_int_in = 8'h01;
    ipi_int_in = 1'b1;
    tick();
    chk_rd("int_estat", CSR_ESTAT, 32'h003f1004);
    wr(CSR_ECFG, 32'h4);
    wr(CSR_CRMD, 32'hc);
    check("int_has_int", 32'(bus.has_int), 32'h1);
    hw_int_in = 8'h0;
    ipi_int_in = 1'b0;
    tick();
    check("int_drop", 32'(bus.has_int), 32'h0);
    wr(CSR_CRMD, 32'h8);
    wr(CSR_ECFG, 32'h0);

    // periodic timer, InitVal=4
    wr(CSR_TCFG, 32'h13);
    chk_rd("tmr_tval_load", CSR_TVAL, 32'd16);
    t0 = cyc;
    wait_timer(t1);
    check("tmr_first_fire", 32'(t1 - t0), 32'd16);
    wr(CSR_TICLR, 32'h1);
    rd(CSR_ESTAT, d);
    check("tmr_ticlr", 32'(d[11]), 32'h0);
    chk_rd("tmr_reload", CSR_TVAL, 32'd16);
    wait_timer(t2);
    check("tmr_period", 32'(t2 - t1), 32'd17);
    wr(CSR_ECFG, 32'h800);
    wr(CSR_CRMD, 32'hc);
    check("tmr_has_int", 32'(bus.has_int), 32'h1);
    wr(CSR_TICLR, 32'h1);
    check("tmr_has_int_clr", 32'(bus.has_int), 32'h0);
    wr(CSR_TCFG, 32'h0);
    wr(CSR_CRMD, 32'h8);
    wr(CSR_ECFG, 32'h0);

    // one-shot timer, fire in the same cycle as TICLR
    wr(CSR_TCFG, 32'h5);
    repeat (3) tick();
    chk_rd("tmr1_tval", CSR_TVAL, 32'd1);
    wr(CSR_TICLR, 32'h1);
    rd(CSR_ESTAT, d);
    check("tmr1_set_wins", 32'(d[11]), 32'h1);
    repeat (2) tick();
    chk_rd("tmr1_hold0", CSR_TVAL, 32'd0);
    wr(CSR_TICLR, 32'h1);
    rd(CSR_ESTAT, d);
    check("tmr1_cleared", 32'(d[11]), 32'h0);
    wr(CSR_TCFG, 32'h0);

    // llbit
    bus.ws_llbit_set = 1'b1;
    bus.ws_llbit = 1'b1;
    tick();
    bus.ws_llbit_set = 1'b0;
    check("ll_set", 32'(bus.llbit), 32'h1);
    ertn();
    check("ll_ertn_clr", 32'(bus.llbit), 32'h0);
    bus.ws_llbit_set = 1'b1;
    tick();
    bus.ws_llbit_set = 1'b0;
    wr(CSR_LLBCTL, 32'h4);
    chk_rd("ll_klo", CSR_LLBCTL, 32'h5);
    ertn();
    check("ll_klo_keep", 32'(bus.llbit), 32'h1);
    chk_rd("ll_klo_clr", CSR_LLBCTL, 32'h1);
    bus.ws_llbit_set = 1'b1;
    bus.ertn_flush = 1'b1;
    tick();
    bus.ws_llbit_set = 1'b0;
    bus.ertn_flush = 1'b0;
    check("ll_ertn_wins", 32'(bus.llbit), 32'h0);
    bus.ws_llbit_set = 1'b1;
    tick();
    bus.ws_llbit_set = 1'b0;
    wr(CSR_LLBCTL, 32'h2);
    check("ll_wcllb", 32'(bus.llbit), 32'h0);

    // excp + ertn + CRMD write in one cycle
    wr(CSR_CRMD, 32'hf);
    wr(CSR_PRMD, 32'h1);
    bus.ertn_flush = 1'b1;
    bus.csr_wr_en = 1'b1;
    bus.wr_csr_addr = CSR_CRMD;
    bus.wr_csr_data = 32'h3;
    excp(6'h1, 32'h1c000300, 1'b0, 1'b0, 32'h0);
    bus.ertn_flush = 1'b0;
    bus.csr_wr_en = 1'b0;
    chk_rd("prio_crmd", CSR_CRMD, 32'h8);
    chk_rd("prio_prmd", CSR_PRMD, 32'h7);
    chk_rd("prio_era", CSR_ERA, 32'h1c000300);
    chk_rd("prio_estat", CSR_ESTAT, 32'h00010000);

    // async reset mid-countdown
    wr(CSR_TCFG, 32'h13);
    repeat (3) tick();
    chk_rd("rst_mid_tval", CSR_TVAL, 32'd13);
    #2;
    reset = 1'b0;
    chk_rd("rst_async_tval", CSR_TVAL, 32'd0);
    chk_rd("rst_async_crmd", CSR_CRMD, 32'h8);
    tick();
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
